// File: rtl/ibr128_pkg.sv
// Types and constants shared by the IBR-128 encrypt- and decrypt-side mode controllers.
// Operating modes, decrypt FSM states and the block width live here.
package ibr128_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    OM_NONE = 2'd0,
    OM_CBC  = 2'd1,
    OM_OFB  = 2'd2,
    OM_CTR  = 2'd3
  } opmode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } dec_state_t;

  // OFB and CTR run the core forwards to make keystream; CBC needs the inverse cipher.
  function automatic logic mode_encrypt(input opmode_t mode);
    return (mode == OM_OFB) || (mode == OM_CTR);
  endfunction

endpackage

// File: rtl/ibr128_chain_state.sv
// Per-message chaining state for the decrypt side: CBC chain, OFB feedback and CTR counter.
// All three reload from {IV, 0} on reset or message open; each advances only on its own strobe.
module ibr128_chain_state
  import ibr128_pkg::*;
#(
  parameter int IV_W  = 32,
  parameter int CTR_W = 32
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic [IV_W-1:0]    IV,
  input  logic               load,
  input  logic               upd_cbc,
  input  logic               upd_ofb,
  input  logic               upd_ctr,
  input  logic [BLOCK_W-1:0] ct_q,
  input  logic [BLOCK_W-1:0] e_data,
  output logic [BLOCK_W-1:0] chain,
  output logic [BLOCK_W-1:0] feedback,
  output logic [BLOCK_W-1:0] counter
);

  localparam int IV_SHIFT = BLOCK_W - IV_W;

  logic [BLOCK_W-1:0] iv_block;
  logic [CTR_W-1:0]   ctr_lo_next;

  // IV sits in the most significant bits; the rest of the block starts at zero.
  assign iv_block    = BLOCK_W'(IV) << IV_SHIFT;
  assign ctr_lo_next = counter[CTR_W-1:0] + CTR_W'(1);

  always_ff @(posedge Clk) begin
    if (!RstN || load) begin
      chain    <= iv_block;
      feedback <= iv_block;
      counter  <= iv_block;
    end else begin
      if (upd_cbc) chain <= ct_q;
      if (upd_ofb) feedback <= e_data;
      // Only the low CTR_W bits count; they wrap and never carry into the upper bits.
      if (upd_ctr) counter <= {counter[BLOCK_W-1:CTR_W], ctr_lo_next};
    end
  end

endmodule

// File: rtl/ibr128_opmode_dec.sv
// Decrypt-side mode controller for the IBR-128 block cipher: takes ciphertext blocks,
// drives the shared block core (CBC decrypt, OFB/CTR keystream) and returns plaintext.
//
// Handshake: a ciphertext block transfers on a cycle where cipherValid and cipherAccept are
// both high; cipherAccept is offered only in IDLE with Enable=1, OB=0 and out of reset.
// plainReady is a one-cycle pulse with plainText valid; plainText then holds until the next result.
module ibr128_opmode_dec
  import ibr128_pkg::*;
#(
  parameter int IV_W  = 32,
  parameter int CTR_W = 32
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               Enable,
  input  logic [1:0]         SOM,
  input  logic               OB,
  input  logic [IV_W-1:0]    IV,
  input  logic               SA,
  input  logic [BLOCK_W-1:0] cipherText,
  input  logic               cipherValid,
  output logic               cipherAccept,
  output logic [BLOCK_W-1:0] plainText,
  output logic               plainReady,
  output logic               encrypt,
  output logic               block_start,
  output logic [BLOCK_W-1:0] pData,
  output logic               sa,
  input  logic               block_ready,
  input  logic [BLOCK_W-1:0] eData,
  output dec_state_t         dbg_state
);

  dec_state_t         state_q, state_d;
  opmode_t            mode_q;
  opmode_t            som_mode;
  logic [BLOCK_W-1:0] ct_q;
  logic [BLOCK_W-1:0] chain, feedback, counter;
  logic [BLOCK_W-1:0] issue_data, pt_core;
  logic               run, take, core_done;

  assign som_mode     = opmode_t'(SOM);
  assign run          = Enable && !OB;
  assign cipherAccept = RstN && run && (state_q == ST_IDLE);
  assign take         = cipherAccept && cipherValid;
  assign core_done    = run && (state_q == ST_WAIT) && block_ready;
  assign dbg_state    = state_q;

  ibr128_chain_state #(
    .IV_W  (IV_W),
    .CTR_W (CTR_W)
  ) u_chain_state (
    .Clk      (Clk),
    .RstN     (RstN),
    .IV       (IV),
    .load     (OB),
    .upd_cbc  (core_done && (mode_q == OM_CBC)),
    .upd_ofb  (core_done && (mode_q == OM_OFB)),
    .upd_ctr  (core_done && (mode_q == OM_CTR)),
    .ct_q     (ct_q),
    .e_data   (eData),
    .chain    (chain),
    .feedback (feedback),
    .counter  (counter)
  );

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // OB and a dropped Enable both abandon the block in flight; nothing is retired.
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (cipherValid) state_d = (som_mode == OM_NONE) ? ST_OUT : ST_ISSUE;
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT:  if (block_ready) state_d = ST_OUT;
        ST_OUT:   state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Core input is chosen from the live SOM at accept so it is ready during ISSUE.
  always_comb begin
    issue_data = cipherText;
    case (som_mode)
      OM_OFB:  issue_data = feedback;
      OM_CTR:  issue_data = counter;
      default: issue_data = cipherText;
    endcase
  end

  always_comb begin
    pt_core = eData ^ ct_q;
    if (mode_q == OM_CBC) pt_core = eData ^ chain;
  end

  // Outputs are registered one step ahead of the state they belong to.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      mode_q      <= OM_NONE;
      ct_q        <= '0;
      plainText   <= '0;
      plainReady  <= 1'b0;
      encrypt     <= 1'b0;
      block_start <= 1'b0;
      pData       <= '0;
      sa          <= 1'b0;
    end else begin
      block_start <= 1'b0;
      plainReady  <= 1'b0;
      if (take) begin
        ct_q   <= cipherText;
        mode_q <= som_mode;
        sa     <= SA;
        if (som_mode == OM_NONE) begin
          plainText  <= cipherText;
          plainReady <= 1'b1;
        end else begin
          block_start <= 1'b1;
          pData       <= issue_data;
          encrypt     <= mode_encrypt(som_mode);
        end
      end
      if (core_done) begin
        plainText  <= pt_core;
        plainReady <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ibr128_opmode_dec.sv
// Bench for ibr128_opmode_dec: directed and random blocks against a mode-level reference model.
// A second instance with a full-width IV reaches the CTR wrap point without billions of blocks.
module tb_ibr128_opmode_dec;
  import ibr128_pkg::*;

  localparam int W = BLOCK_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         ob = 1'b0;
  logic         sa_in = 1'b0;
  logic         cipher_valid = 1'b0;
  logic         block_ready = 1'b0;
  logic [1:0]   som = 2'd0;
  logic [31:0]  iv = 32'h0;
  logic [W-1:0] iv_w = '0;
  logic [W-1:0] cipher_text = '0;
  logic [W-1:0] e_data = '0;

  logic         accept_a, ready_a, encrypt_a, start_a, sa_a;
  logic [W-1:0] pt_a, pdata_a;
  dec_state_t   state_a;
  logic         accept_b, ready_b, encrypt_b, start_b, sa_b;
  logic [W-1:0] pt_b, pdata_b;
  dec_state_t   state_b;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_chain [2];
  logic [W-1:0] m_fb    [2];
  logic [W-1:0] m_ctr   [2];
  logic [W-1:0] last_pt_a, last_pdata_a, last_pdata_b;

  always #5 clk = ~clk;

  ibr128_opmode_dec u_dut (
    .Clk(clk), .RstN(rst_n), .Enable(enable), .SOM(som), .OB(ob), .IV(iv), .SA(sa_in),
    .cipherText(cipher_text), .cipherValid(cipher_valid), .cipherAccept(accept_a),
    .plainText(pt_a), .plainReady(ready_a), .encrypt(encrypt_a), .block_start(start_a),
    .pData(pdata_a), .sa(sa_a), .block_ready(block_ready), .eData(e_data), .dbg_state(state_a)
  );

  ibr128_opmode_dec #(.IV_W(W), .CTR_W(32)) u_dut_wide (
    .Clk(clk), .RstN(rst_n), .Enable(enable), .SOM(som), .OB(ob), .IV(iv_w), .SA(sa_in),
    .cipherText(cipher_text), .cipherValid(cipher_valid), .cipherAccept(accept_b),
    .plainText(pt_b), .plainReady(ready_b), .encrypt(encrypt_b), .block_start(start_b),
    .pData(pdata_b), .sa(sa_b), .block_ready(block_ready), .eData(e_data), .dbg_state(state_b)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_iv(input logic [31:0] v);
    iv   = v;
    iv_w = {v, 64'h0F1E_2D3C_4B5A_6978, 32'hFFFF_FFFF};
  endtask

  // Start of a message: every mode's state is the IV placed at the top of the block.
  task automatic model_load();
    for (int k = 0; k < 2; k++) begin
      m_chain[k] = (k == 0) ? {iv, 96'h0} : iv_w;
      m_fb[k]    = m_chain[k];
      m_ctr[k]   = m_chain[k];
    end
  endtask

  function automatic logic [W-1:0] exp_pdata(input int k, input opmode_t mode,
                                             input logic [W-1:0] ct);
    case (mode)
      OM_OFB:  return m_fb[k];
      OM_CTR:  return m_ctr[k];
      default: return ct;
    endcase
  endfunction

  function automatic logic [W-1:0] retire(input int k, input opmode_t mode,
                                          input logic [W-1:0] ct, input logic [W-1:0] e);
    logic [W-1:0] pt;
    case (mode)
      OM_CBC: begin pt = e ^ m_chain[k]; m_chain[k] = ct; end
      OM_OFB: begin pt = e ^ ct; m_fb[k] = e; end
      default: begin pt = e ^ ct; m_ctr[k][31:0] = m_ctr[k][31:0] + 32'd1; end
    endcase
    return pt;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_ready"}, ready_a, 1'b0);
    chk1({tag, "_start"}, start_a, 1'b0);
    chk1({tag, "_encrypt"}, encrypt_a, 1'b0);
    chk1({tag, "_sa"}, sa_a, 1'b0);
    chk1({tag, "_accept"}, accept_a, 1'b0);
    chk({tag, "_pt"}, pt_a, '0);
    chk({tag, "_pdata"}, pdata_a, '0);
    chk({tag, "_state"}, W'(state_a), W'(ST_IDLE));
  endtask

  task automatic wait_accept();
    int n = 0;
    while (accept_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk1("accept_offered", accept_a, 1'b1);
  endtask

  // abort: 0 none, 1 OB in WAIT, 2 Enable low in WAIT, 3 reset in WAIT
  task automatic run_block(input opmode_t mode, input logic [W-1:0] ct, input logic [W-1:0] e,
                           input int extra, input int abort);
    logic s;
    logic [W-1:0] exp_a, exp_b;
    s = 1'($urandom_range(0, 1));
    wait_accept();
    som = mode; cipher_text = ct; sa_in = s; cipher_valid = 1'b1;
    @(negedge clk);
    cipher_valid = 1'b0;
    som = 2'($urandom_range(0, 3));
    sa_in = ~s;
    chk1("sa_latched", sa_a, s);
    if (mode == OM_NONE) begin
      last_pt_a = pt_a;
      chk1("none_ready", ready_a, 1'b1);
      chk("none_pt", pt_a, ct);
      chk1("none_no_start", start_a, 1'b0);
      @(negedge clk);
      chk1("none_pulse_end", ready_a, 1'b0);
      chk1("none_no_start2", start_a, 1'b0);
      return;
    end
    exp_a = exp_pdata(0, mode, ct);
    exp_b = exp_pdata(1, mode, ct);
    last_pdata_a = pdata_a;
    last_pdata_b = pdata_b;
    chk1("issue_start", start_a, 1'b1);
    chk("issue_pdata", pdata_a, exp_a);
    chk("issue_pdata_wide", pdata_b, exp_b);
    chk1("issue_encrypt", encrypt_a, mode != OM_CBC);
    // A core result arriving during ISSUE is not from this block and must be ignored.
    block_ready = 1'b1; e_data = ~e;
    @(negedge clk);
    block_ready = 1'b0;
    chk1("wait_start_low", start_a, 1'b0);
    chk1("wait_no_ready", ready_a, 1'b0);
    chk("wait_pdata_held", pdata_a, exp_a);
    for (int i = 0; i < extra; i++) begin
      @(negedge clk);
      chk1("wait_idle_ready", ready_a, 1'b0);
    end
    if (abort != 0) begin
      if (abort == 1) begin
        ob = 1'b1;
        @(negedge clk);
        ob = 1'b0;
        model_load();
      end else if (abort == 2) begin
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
      end else begin
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_in_wait");
        rst_n = 1'b1;
        model_load();
        #1;
        chk1("accept_after_rst", accept_a, 1'b1);
      end
      chk("abort_state", W'(state_a), W'(ST_IDLE));
      block_ready = 1'b1; e_data = e;
      @(negedge clk);
      block_ready = 1'b0;
      chk1("abort_no_ready", ready_a, 1'b0);
      chk1("abort_no_ready_wide", ready_b, 1'b0);
      return;
    end
    block_ready = 1'b1; e_data = e;
    @(negedge clk);
    block_ready = 1'b0;
    last_pt_a = pt_a;
    chk1("out_ready", ready_a, 1'b1);
    chk("out_pt", pt_a, retire(0, mode, ct, e));
    chk("out_pt_wide", pt_b, retire(1, mode, ct, e));
    @(negedge clk);
    chk1("out_pulse_end", ready_a, 1'b0);
    chk("back_to_idle", W'(state_a), W'(ST_IDLE));
  endtask

  function automatic logic [W-1:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] a, b, d0, d1, k0, k1, ct0;
    set_iv(32'hDEAD_BEEF);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_load();
    #1;
    chk1("accept_out_of_reset", accept_a, 1'b1);
    @(negedge clk);

    // CTR example, then the next counter value; the wide instance wraps its low 32 bits.
    run_block(OM_CTR, 128'h1, 128'hFF, 0, 0);
    chk("ctr_ex_pdata", last_pdata_a, {32'hDEAD_BEEF, 96'h0});
    chk("ctr_ex_pt", last_pt_a, 128'hFE);
    run_block(OM_CTR, rand_block(), rand_block(), 1, 0);
    chk("ctr_next_pdata", last_pdata_a, {32'hDEAD_BEEF, 64'h0, 32'h1});
    chk("ctr_wrap_pdata", last_pdata_b, {iv_w[W-1:32], 32'h0});

    // CBC two-block chain.
    a = rand_block(); b = rand_block(); d0 = rand_block(); d1 = rand_block();
    run_block(OM_CBC, a, d0, 0, 0);
    chk("cbc_pt0", last_pt_a, d0 ^ {32'hDEAD_BEEF, 96'h0});
    run_block(OM_CBC, b, d1, 2, 0);
    chk("cbc_pdata1", last_pdata_a, b);
    chk("cbc_pt1", last_pt_a, d1 ^ a);

    // OFB: keystream feeds back as the next core input.
    k0 = rand_block(); k1 = rand_block(); ct0 = rand_block();
    run_block(OM_OFB, ct0, k0, 0, 0);
    chk("ofb_pt0", last_pt_a, k0 ^ ct0);
    run_block(OM_OFB, ct0, k1, 1, 0);
    chk("ofb_pdata1", last_pdata_a, k0);

    run_block(OM_NONE, 128'h1234, '0, 0, 0);
    chk("none_ex_pt", last_pt_a, 128'h1234);

    // OB while waiting on the core: result dropped, counter restarts from the new IV.
    set_iv($urandom());
    run_block(OM_CTR, rand_block(), rand_block(), 1, 1);
    run_block(OM_CTR, rand_block(), rand_block(), 0, 0);
    chk("ob_restart_pdata", last_pdata_a, {iv, 96'h0});

    // Enable dropped mid-block: chain must not advance.
    run_block(OM_CBC, rand_block(), rand_block(), 0, 2);
    run_block(OM_CBC, rand_block(), rand_block(), 0, 0);

    // OB together with cipherValid: OB wins.
    wait_accept();
    ob = 1'b1; cipher_valid = 1'b1; som = OM_CBC; cipher_text = rand_block();
    #1;
    chk1("ob_blocks_accept", accept_a, 1'b0);
    @(negedge clk);
    ob = 1'b0; cipher_valid = 1'b0;
    model_load();
    chk1("ob_no_start", start_a, 1'b0);
    chk1("ob_no_ready", ready_a, 1'b0);
    chk("ob_state", W'(state_a), W'(ST_IDLE));

    // Core result while idle is ignored.
    block_ready = 1'b1; e_data = rand_block();
    @(negedge clk);
    block_ready = 1'b0;
    chk1("idle_br_ignored", ready_a, 1'b0);
    chk("idle_br_state", W'(state_a), W'(ST_IDLE));

    run_block(OM_OFB, rand_block(), rand_block(), 0, 3);
    run_block(OM_OFB, rand_block(), rand_block(), 0, 0);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 8) set_iv($urandom());
      run_block(opmode_t'($urandom_range(0, 3)), rand_block(), rand_block(),
                $urandom_range(0, 3), (r >= 8) ? r - 7 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
